// File: rtl/zoom_hdmi_pkg.sv
// Shared widths, blanking value and FSM encoding for the HDMI zoom-output pixel unpacker.
package zoom_hdmi_pkg;

  localparam int PIX_W        = 24;
  localparam int PIX_PER_WORD = 10;
  localparam int WORD_W       = PIX_W * PIX_PER_WORD;
  localparam int IDX_W        = $clog2(PIX_PER_WORD);

  localparam logic [PIX_W-1:0] BLANK_PIX = 24'h000000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    RUN      = 2'd2
  } state_e;

endpackage

// File: rtl/zoom_hdmi_pix_unpack_if.sv
// FIFO-side and pixel-side signals of the unpacker; the unpacker uses the slave modport.
interface zoom_hdmi_pix_unpack_if;
  import zoom_hdmi_pkg::*;

  logic              frame_start;
  logic [WORD_W-1:0] fifo_rd_data;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic              pix_req;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              underflow;
  logic              underflow_sticky;

  modport master (
    output frame_start, fifo_rd_data, fifo_empty, pix_req,
    input  fifo_rd_en, pix_data, pix_valid, underflow, underflow_sticky
  );

  modport slave (
    input  frame_start, fifo_rd_data, fifo_empty, pix_req,
    output fifo_rd_en, pix_data, pix_valid, underflow, underflow_sticky
  );

endinterface

// File: rtl/zoom_hdmi_word_buf.sv
// Two-slot (cur/nxt) prefetch buffer for FIFO words, with an outstanding-read credit
// counter and a drop counter that discards returns belonging to a flushed frame.
module zoom_hdmi_word_buf
  import zoom_hdmi_pkg::*;
#(
  parameter int FIFO_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              rd_en_i,
  input  logic [WORD_W-1:0] rd_data_i,
  input  logic              consume_i,
  output logic [WORD_W-1:0] cur_data_o,
  output logic              cur_valid_o,
  output logic              credit_ok_o
);

  logic [WORD_W-1:0]      cur_q, cur_d;
  logic [WORD_W-1:0]      nxt_q, nxt_d;
  logic                   cur_vld_q, cur_vld_d;
  logic                   nxt_vld_q, nxt_vld_d;
  logic [1:0]             out_cnt_q, out_cnt_d;
  logic [1:0]             drop_cnt_q, drop_cnt_d;
  logic [FIFO_RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic                   ret_vld;
  logic                   ret_keep;
  logic [2:0]             used_cnt;

  // Track each issued read until its data shows up on rd_data_i.
  if (FIFO_RD_LAT == 1) begin : g_lat1
    assign rd_pipe_d = rd_en_i;
  end else begin : g_latn
    assign rd_pipe_d = {rd_pipe_q[FIFO_RD_LAT-2:0], rd_en_i};
  end

  assign ret_vld  = rd_pipe_q[FIFO_RD_LAT-1];
  assign ret_keep = ret_vld && !flush_i && (drop_cnt_q == 2'd0);

  assign used_cnt    = 3'(cur_vld_q) + 3'(nxt_vld_q) + 3'(out_cnt_q);
  assign credit_ok_o = (used_cnt < 3'd2);
  assign cur_data_o  = cur_q;
  assign cur_valid_o = cur_vld_q;

  always_comb begin
    out_cnt_d  = out_cnt_q + 2'(rd_en_i) - 2'(ret_vld);
    drop_cnt_d = drop_cnt_q;
    if (flush_i) begin
      drop_cnt_d = out_cnt_q - 2'(ret_vld);
    end else if (ret_vld && (drop_cnt_q != 2'd0)) begin
      drop_cnt_d = drop_cnt_q - 2'd1;
    end
  end

  // Shift first, then a kept return lands in whichever slot is free afterwards.
  always_comb begin
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    cur_vld_d = cur_vld_q;
    nxt_vld_d = nxt_vld_q;
    if (flush_i) begin
      cur_vld_d = 1'b0;
      nxt_vld_d = 1'b0;
    end else begin
      if (consume_i) begin
        cur_d     = nxt_q;
        cur_vld_d = nxt_vld_q;
        nxt_vld_d = 1'b0;
      end
      if (ret_keep) begin
        if (!cur_vld_d) begin
          cur_d     = rd_data_i;
          cur_vld_d = 1'b1;
        end else begin
          nxt_d     = rd_data_i;
          nxt_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q      <= '0;
      nxt_q      <= '0;
      cur_vld_q  <= 1'b0;
      nxt_vld_q  <= 1'b0;
      out_cnt_q  <= 2'd0;
      drop_cnt_q <= 2'd0;
      rd_pipe_q  <= '0;
    end else begin
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      cur_vld_q  <= cur_vld_d;
      nxt_vld_q  <= nxt_vld_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      rd_pipe_q  <= rd_pipe_d;
    end
  end

endmodule

// File: rtl/zoom_hdmi_pix_unpack.sv
// Serialises 240-bit zoom FIFO words into 24-bit HDMI pixels, one per pix_req, 1-cycle latency.
// Optional saturating frame statistics are enabled with `define ZOOM_HDMI_UNPACK_STAT_EN.
module zoom_hdmi_pix_unpack
  import zoom_hdmi_pkg::*;
#(
  parameter int FIFO_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  zoom_hdmi_pix_unpack_if.slave bus
`ifdef ZOOM_HDMI_UNPACK_STAT_EN
  ,
  output logic [23:0]           stat_pix_cnt,
  output logic [15:0]           stat_uf_cnt
`endif
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PIX_W-1:0]   pix_data_q, pix_data_d;
  logic               pix_valid_q;
  logic               underflow_q, underflow_d;
  logic               sticky_q, sticky_d;
  logic               consume;
  logic               served;
  logic               rd_en;
  logic               cur_valid;
  logic               credit_ok;
  logic [WORD_W-1:0]  cur_data;
  logic [PIX_W-1:0]   pix_arr [PIX_PER_WORD];

  zoom_hdmi_word_buf #(
    .FIFO_RD_LAT (FIFO_RD_LAT)
  ) u_word_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (bus.frame_start),
    .rd_en_i     (rd_en),
    .rd_data_i   (bus.fifo_rd_data),
    .consume_i   (consume),
    .cur_data_o  (cur_data),
    .cur_valid_o (cur_valid),
    .credit_ok_o (credit_ok)
  );

  for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_unpack
    assign pix_arr[gi] = cur_data[gi*PIX_W +: PIX_W];
  end

  assign rd_en = (state_q != IDLE) && !bus.fifo_empty && credit_ok;

  // frame_start overrides everything, including a coincident pix_req.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pix_data_d  = BLANK_PIX;
    underflow_d = 1'b0;
    sticky_d    = sticky_q;
    consume     = 1'b0;
    served      = 1'b0;
    if (bus.frame_start) begin
      state_d  = PREFETCH;
      idx_d    = '0;
      sticky_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        PREFETCH: begin
          if (cur_valid) state_d = RUN;
        end
        RUN: begin
          if (bus.pix_req && cur_valid) begin
            served     = 1'b1;
            pix_data_d = pix_arr[idx_q];
            if (idx_q == IDX_W'(PIX_PER_WORD - 1)) begin
              idx_d   = '0;
              consume = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      if (bus.pix_req && !served) begin
        underflow_d = 1'b1;
        sticky_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      underflow_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= bus.pix_req;
      underflow_q <= underflow_d;
      sticky_q    <= sticky_d;
    end
  end

  assign bus.fifo_rd_en       = rd_en;
  assign bus.pix_data         = pix_data_q;
  assign bus.pix_valid        = pix_valid_q;
  assign bus.underflow        = underflow_q;
  assign bus.underflow_sticky = sticky_q;

`ifdef ZOOM_HDMI_UNPACK_STAT_EN
  logic [23:0] pix_run_q, stat_pix_q;
  logic [15:0] uf_run_q, stat_uf_q;

  // Running counts are snapshotted into the visible registers at each frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_run_q  <= '0;
      uf_run_q   <= '0;
      stat_pix_q <= '0;
      stat_uf_q  <= '0;
    end else if (bus.frame_start) begin
      stat_pix_q <= pix_run_q;
      stat_uf_q  <= uf_run_q;
      pix_run_q  <= '0;
      uf_run_q   <= '0;
    end else begin
      if (served && (pix_run_q != '1)) pix_run_q <= pix_run_q + 1'b1;
      if (underflow_d && (uf_run_q != '1)) uf_run_q <= uf_run_q + 1'b1;
    end
  end

  assign stat_pix_cnt = stat_pix_q;
  assign stat_uf_cnt  = stat_uf_q;
`endif

endmodule

// File: tb/tb_zoom_hdmi_pix_unpack.sv
// Scoreboard bench: two unpacker lanes (FIFO_RD_LAT 1 and 2) share one directed stimulus stream.
module tb_zoom_hdmi_pix_unpack;
  import zoom_hdmi_pkg::*;

  localparam int NLANE = 2;
  localparam logic [WORD_W-1:0] POISON = {PIX_PER_WORD{24'hBADBAD}};

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             uf;
  } exp_t;

  logic clk;
  logic rst_n;
  logic frame_start;
  logic pix_req;

  int checks   = 0;
  int failures = 0;
  int push_cnt = 0;
  int pop_cnt [NLANE];

  logic [WORD_W-1:0] mem [0:255];
  exp_t              exp_q [NLANE][$];
  logic [27:0]       rst_vec [NLANE];
  logic              sticky_v [NLANE];
  logic [23:0]       stat_pix [NLANE];
  logic [15:0]       stat_uf [NLANE];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
    localparam int LAT = gi + 1;
    zoom_hdmi_pix_unpack_if bus ();
    logic [WORD_W-1:0] dpipe [LAT];
    exp_t e;

    assign bus.frame_start  = frame_start;
    assign bus.pix_req      = pix_req;
    assign bus.fifo_empty   = (pop_cnt[gi] == push_cnt);
    assign bus.fifo_rd_data = dpipe[LAT-1];
    assign rst_vec[gi]  = {bus.pix_data, bus.pix_valid, bus.underflow,
                           bus.underflow_sticky, bus.fifo_rd_en};
    assign sticky_v[gi] = bus.underflow_sticky;
`ifndef ZOOM_HDMI_UNPACK_STAT_EN
    assign stat_pix[gi] = '0;
    assign stat_uf[gi]  = '0;
`endif

    zoom_hdmi_pix_unpack #(
      .FIFO_RD_LAT (LAT)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus)
`ifdef ZOOM_HDMI_UNPACK_STAT_EN
      ,
      .stat_pix_cnt (stat_pix[gi]),
      .stat_uf_cnt  (stat_uf[gi])
`endif
    );

    // FIFO model: registered read data with LAT cycles of latency, poison otherwise.
    initial pop_cnt[gi] = 0;
    always @(posedge clk) begin
      if (bus.fifo_rd_en) begin
        checks++;
        if (pop_cnt[gi] == push_cnt) begin
          failures++;
          $display("FAIL lane%0d pop_when_empty actual=rd_en required=no_rd_en", gi);
          dpipe[0] <= POISON;
        end else begin
          dpipe[0]    <= mem[pop_cnt[gi]];
          pop_cnt[gi] <= pop_cnt[gi] + 1;
        end
      end else begin
        dpipe[0] <= POISON;
      end
      for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end

    // Monitor: every pix_valid consumes one scoreboard entry.
    always @(negedge clk) begin
      if (rst_n && bus.pix_valid) begin
        checks++;
        if (exp_q[gi].size() == 0) begin
          failures++;
          $display("FAIL lane%0d unexpected_pixel actual=%h/uf%b required=none",
                   gi, bus.pix_data, bus.underflow);
        end else begin
          e = exp_q[gi].pop_front();
          if (bus.pix_data !== e.data || bus.underflow !== e.uf) begin
            failures++;
            $display("FAIL lane%0d pixel actual=%h/uf%b required=%h/uf%b",
                     gi, bus.pix_data, bus.underflow, e.data, e.uf);
          end else begin
            $display("lane%0d pixel %h uf=%b ok", gi, bus.pix_data, bus.underflow);
          end
        end
      end
    end
  end

  function automatic logic [PIX_W-1:0] pix_val(int w, int k);
    logic [11:0] wv;
    logic [3:0]  kv;
    wv = w[11:0];
    kv = k[3:0];
    return {8'hC3, wv, kv};
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(logic [PIX_W-1:0] d, logic uf);
    for (int g = 0; g < NLANE; g++) exp_q[g].push_back({d, uf});
  endtask

  task automatic push_word();
    logic [WORD_W-1:0] wd;
    for (int k = 0; k < PIX_PER_WORD; k++) wd[k*PIX_W +: PIX_W] = pix_val(push_cnt, k);
    mem[push_cnt] = wd;
    push_cnt++;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      frame_start = 1'b0;
      pix_req     = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic serve(int w, int k);
    push_exp(pix_val(w, k), 1'b0);
    frame_start = 1'b0;
    pix_req     = 1'b1;
    @(negedge clk);
    pix_req = 1'b0;
  endtask

  task automatic starve();
    push_exp(BLANK_PIX, 1'b1);
    frame_start = 1'b0;
    pix_req     = 1'b1;
    @(negedge clk);
    pix_req = 1'b0;
  endtask

  task automatic fstart(bit with_req);
    if (with_req) push_exp(BLANK_PIX, 1'b0);
    frame_start = 1'b1;
    pix_req     = with_req;
    @(negedge clk);
    frame_start = 1'b0;
    pix_req     = 1'b0;
  endtask

  task automatic check_pops(string name, int req);
    for (int g = 0; g < NLANE; g++) check($sformatf("%s_lane%0d", name, g), pop_cnt[g], req);
  endtask

  task automatic check_sticky(string name, int req);
    for (int g = 0; g < NLANE; g++) check($sformatf("%s_lane%0d", name, g), int'(sticky_v[g]), req);
  endtask

  initial begin
    int w0;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    pix_req     = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NLANE; g++) check($sformatf("reset_outputs_lane%0d", g), int'(rst_vec[g]), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Preloaded words must not be popped while IDLE.
    push_word();
    push_word();
    idle(2);
    check_pops("idle_no_pop", 0);
    for (int g = 0; g < NLANE; g++) check($sformatf("idle_outputs_lane%0d", g), int'(rst_vec[g]), 0);

    // Two words, 20 consecutive pixels.
    fstart(0);
    idle(8);
    for (int i = 0; i < 20; i++) serve(i / PIX_PER_WORD, i % PIX_PER_WORD);
    idle(2);
    check_pops("two_word_pops", 2);
    check_sticky("two_word_sticky", 0);

    // One 1920-pixel line with the FIFO always stocked.
    fstart(0);
    w0 = push_cnt;
    for (int i = 0; i < 192; i++) push_word();
    idle(8);
    for (int i = 0; i < 1920; i++) serve(w0 + i / PIX_PER_WORD, i % PIX_PER_WORD);
    idle(2);
    check_pops("line_pops", 194);
    check_sticky("line_sticky", 0);

    // Starvation after one word, then refill resumes at pixel 0 of the new word.
    fstart(0);
    w0 = push_cnt;
    push_word();
    idle(8);
    for (int k = 0; k < PIX_PER_WORD; k++) serve(w0, k);
    repeat (3) starve();
    check_sticky("starve_sticky", 1);
    push_word();
    idle(8);
    for (int k = 0; k < PIX_PER_WORD; k++) serve(w0 + 1, k);
    check_sticky("refill_sticky", 1);
    check_pops("refill_pops", 196);

    // frame_start at index 4 while a read is in flight: that word is dropped.
    fstart(0);
    w0 = push_cnt;
    push_word();
    idle(8);
    for (int k = 0; k < 4; k++) serve(w0, k);
    push_word();
    idle(1);
    fstart(0);
    idle(3);
    push_word();
    idle(8);
    for (int k = 0; k < 3; k++) serve(w0 + 2, k);
    check_pops("drop_pops", 199);

    // Underflow in PREFETCH, then frame_start coinciding with pix_req.
    fstart(0);
    idle(3);
    starve();
    check_sticky("prefetch_uf_sticky", 1);
    fstart(1);
    check_sticky("fs_req_sticky", 0);

    // 100 served plus 3 starved requests in one frame.
    fstart(0);
    w0 = push_cnt;
    for (int i = 0; i < 10; i++) push_word();
    idle(8);
    for (int i = 0; i < 100; i++) serve(w0 + i / PIX_PER_WORD, i % PIX_PER_WORD);
    repeat (3) starve();
    fstart(0);
    check_pops("stat_frame_pops", 209);
    check_sticky("stat_frame_sticky", 0);
`ifdef ZOOM_HDMI_UNPACK_STAT_EN
    for (int g = 0; g < NLANE; g++) begin
      check($sformatf("stat_pix_cnt_lane%0d", g), int'(stat_pix[g]), 100);
      check($sformatf("stat_uf_cnt_lane%0d", g), int'(stat_uf[g]), 3);
    end
`endif

    idle(4);
    for (int g = 0; g < NLANE; g++) check($sformatf("scoreboard_drained_lane%0d", g), exp_q[g].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
